// File: rtl/seq_divider_4bit.sv
// Iterative restoring divider: unsigned dividend / divisor, one quotient bit
// per clock, MSB first, with a start/done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; operands latched on an accepted request
// S_RUN  | one shift/trial-subtract iteration per clock, WIDTH in total
// S_DONE | results valid, done pulses for one cycle, then back to IDLE
module seq_divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [CW-1:0]    count;

  // The shift is done one bit wider than P so that every bit of P feeds the
  // trial subtract; the top bit of the difference is then the borrow.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  // One restoring-division step: shift {P,Q}, trial subtract, keep or restore.
  always_comb begin
    shifted   = {p_reg, q_reg[WIDTH-1]};
    trial     = shifted - {2'b00, dsr_reg};
    p_nxt     = trial[WIDTH:0];
    q_nxt     = {q_reg[WIDTH-2:0], 1'b1};
    if (trial[WIDTH+1]) begin
      p_nxt = shifted[WIDTH:0];
      q_nxt = {q_reg[WIDTH-2:0], 1'b0};
    end
    last_iter = (count == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers that only
  // change on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg       <= '0;
      q_reg       <= '0;
      dsr_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dsr_reg <= divisor;
            q_reg   <= dividend;
            p_reg   <= '0;
            count   <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          count <= count + CW'(1);
          if (last_iter) begin
            quotient    <= q_nxt;
            remainder   <= p_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
